// File: rtl/gb_vram_pkg.sv
// Purpose: shared types and constants for the VRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gb_vram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_PPU,
    OWN_DMA,
    OWN_CPU
  } owner_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } arb_state_e;

  // STAT mode in which the PPU owns VRAM exclusively
  localparam logic [1:0] PPU_MODE_DRAW     = 2'd3;
  // Open-bus value seen by a locked-out CPU/DMA read
  localparam logic [7:0] VRAM_BLOCKED_DATA = 8'hFF;

endpackage

// File: rtl/vram_arbiter.sv
// Purpose: shares the single VRAM port between PPU, OAM DMA and CPU, applying mode-3 lockout.
// Latency: req -> ack in 3 cycles; one transaction per 4 cycles.
// Backpressure: requesters hold req until their one-cycle ack; losers wait in priority order.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   lcd_on, ppu_mode            lockout control, sampled at grant
//   ppu_req/addr/rdata/ack      PPU read channel (never locked out)
//   dma_req/addr/rdata/ack      DMA read channel
//   cpu_req/we/addr/wdata/rdata/ack  CPU read/write channel
//   vram_en/we/addr/din/dout    VRAM macro pins (dout registered, 1-cycle latency)
module vram_arbiter
  import gb_vram_pkg::*;
#(
  parameter int                 ADDR_W     = 13,
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  BLOCK_DATA = VRAM_BLOCKED_DATA,
  parameter logic [1:0]         LOCK_MODE  = PPU_MODE_DRAW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_on,
  input  logic [1:0]        ppu_mode,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [DATA_W-1:0] ppu_rdata,
  output logic              ppu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              vram_en,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, grant;
  logic              we_q, blocked_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ppu_rdata_q, dma_rdata_q, cpu_rdata_q;

  logic [ADDR_W-1:0] grant_addr;
  logic              grant_we;
  logic              grant_blocked;

  // Fixed priority PPU > DMA > CPU, plus the request fields of the winner.
  always_comb begin
    grant      = OWN_NONE;
    grant_addr = addr_q;
    grant_we   = 1'b0;
    if (ppu_req) begin
      grant      = OWN_PPU;
      grant_addr = ppu_addr;
    end else if (dma_req) begin
      grant      = OWN_DMA;
      grant_addr = dma_addr;
    end else if (cpu_req) begin
      grant      = OWN_CPU;
      grant_addr = cpu_addr;
      grant_we   = cpu_we;
    end
  end

  // Lockout is decided once, at grant; later mode changes cannot tear an access.
  assign grant_blocked = lcd_on && (ppu_mode == LOCK_MODE) && (grant != OWN_PPU);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant != OWN_NONE) state_d = ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      blocked_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ppu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        owner_q <= grant;
        if (grant != OWN_NONE) begin
          addr_q    <= grant_addr;
          we_q      <= grant_we;
          wdata_q   <= cpu_wdata;
          blocked_q <= grant_blocked;
        end
      end
      // vram_dout is only meaningful the cycle after an enabled ACCESS
      if (state_q == CAPTURE) begin
        case (owner_q)
          OWN_PPU: ppu_rdata_q <= vram_dout;
          OWN_DMA: dma_rdata_q <= blocked_q ? BLOCK_DATA : vram_dout;
          OWN_CPU: if (!we_q) cpu_rdata_q <= blocked_q ? BLOCK_DATA : vram_dout;
          default: ;
        endcase
      end
    end
  end

  // Decoded straight from state so reset clears the pins immediately.
  assign vram_en   = (state_q == ACCESS) && !blocked_q;
  assign vram_we   = vram_en && (owner_q == OWN_CPU) && we_q;
  assign vram_addr = addr_q;
  assign vram_din  = wdata_q;

  assign ppu_ack   = (state_q == RESP) && (owner_q == OWN_PPU);
  assign dma_ack   = (state_q == RESP) && (owner_q == OWN_DMA);
  assign cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);

  assign ppu_rdata = ppu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule
